// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle MIPS datapath.
// Walks fetch/decode/execute/memory/writeback for each instruction held in IR
// and drives the datapath selects, write enables and ALU control. Outputs are
// decoded from the current state; FETCH and BEQEX also look at mem_ready/zero.
module multicycle_ctrl #(
    parameter int unsigned MEM_HANDSHAKE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memwrite,
    output logic        iord,
    output logic        irwrite,
    output logic        pcen,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        st_idle    = 4'd0,
        st_fetch   = 4'd1,
        st_decode  = 4'd2,
        st_memadr  = 4'd3,
        st_memrd   = 4'd4,
        st_memwb   = 4'd5,
        st_memwr   = 4'd6,
        st_rtypeex = 4'd7,
        st_rtypewb = 4'd8,
        st_beqex   = 4'd9,
        st_addiex  = 4'd10,
        st_addiwb  = 4'd11,
        st_jex     = 4'd12
    } state_t;

    // opcode field values
    localparam logic [5:0] op_rtype = 6'b000000;
    localparam logic [5:0] op_lw    = 6'b100011;
    localparam logic [5:0] op_sw    = 6'b101011;
    localparam logic [5:0] op_beq   = 6'b000100;
    localparam logic [5:0] op_addi  = 6'b001000;
    localparam logic [5:0] op_j     = 6'b000010;

    // funct field values for R-type
    localparam logic [5:0] fn_add = 6'b100000;
    localparam logic [5:0] fn_sub = 6'b100010;
    localparam logic [5:0] fn_and = 6'b100100;
    localparam logic [5:0] fn_or  = 6'b100101;
    localparam logic [5:0] fn_slt = 6'b101010;

    // ALU control codes
    localparam logic [2:0] alu_add = 3'b010;
    localparam logic [2:0] alu_sub = 3'b110;
    localparam logic [2:0] alu_and = 3'b000;
    localparam logic [2:0] alu_or  = 3'b001;
    localparam logic [2:0] alu_slt = 3'b111;

    state_t      cur_state;
    state_t      nxt_state;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        mem_rdy;
    logic        pcwrite;
    logic        branch;
    logic        funct_ok;
    logic [2:0]  funct_alu;
    logic        unused_instr_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Register specifiers and immediate bits go straight to the datapath.
    assign unused_instr_bits = ^instr[25:6];

    // Without the handshake every memory access completes in one cycle.
    assign mem_rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    assign state = cur_state;
    assign pcen  = pcwrite | (branch & zero);

    // State register; async reset parks the FSM in IDLE, which also drops
    // mem_req/memwrite immediately since outputs decode from state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= st_idle;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // R-type funct decode into ALU control.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = alu_add;
        case (funct)
            fn_add:  funct_alu = alu_add;
            fn_sub:  funct_alu = alu_sub;
            fn_and:  funct_alu = alu_and;
            fn_or:   funct_alu = alu_or;
            fn_slt:  funct_alu = alu_slt;
            default: funct_ok  = 1'b0;
        endcase
    end

    // Next-state and per-state control outputs.
    always_comb begin
        nxt_state  = cur_state;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = alu_add;
        illegal    = 1'b0;

        case (cur_state)
            st_idle: begin
                nxt_state = st_fetch;
            end

            st_fetch: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (mem_rdy) begin
                    irwrite   = 1'b1;
                    pcwrite   = 1'b1;
                    nxt_state = st_decode;
                end
            end

            st_decode: begin
                alusrcb = 2'b11;
                case (op)
                    op_lw,
                    op_sw:    nxt_state = st_memadr;
                    op_rtype: nxt_state = st_rtypeex;
                    op_beq:   nxt_state = st_beqex;
                    op_addi:  nxt_state = st_addiex;
                    op_j:     nxt_state = st_jex;
                    default: begin
                        illegal   = 1'b1;
                        nxt_state = st_fetch;
                    end
                endcase
            end

            st_memadr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == op_lw) begin
                    nxt_state = st_memrd;
                end else if (op == op_sw) begin
                    nxt_state = st_memwr;
                end else begin
                    nxt_state = st_fetch;
                end
            end

            st_memrd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_rdy) begin
                    nxt_state = st_memwb;
                end
            end

            st_memwb: begin
                regwrite  = 1'b1;
                memtoreg  = 1'b1;
                nxt_state = st_fetch;
            end

            st_memwr: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_rdy) begin
                    nxt_state = st_fetch;
                end
            end

            st_rtypeex: begin
                alusrca = 1'b1;
                alusrcb = 2'b00;
                if (funct_ok) begin
                    alucontrol = funct_alu;
                    nxt_state  = st_rtypewb;
                end else begin
                    illegal   = 1'b1;
                    nxt_state = st_fetch;
                end
            end

            st_rtypewb: begin
                regwrite  = 1'b1;
                regdst    = 1'b1;
                nxt_state = st_fetch;
            end

            st_beqex: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = alu_sub;
                pcsrc      = 2'b01;
                branch     = 1'b1;
                nxt_state  = st_fetch;
            end

            st_addiex: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                nxt_state = st_addiwb;
            end

            st_addiwb: begin
                regwrite  = 1'b1;
                nxt_state = st_fetch;
            end

            st_jex: begin
                pcsrc     = 2'b10;
                pcwrite   = 1'b1;
                nxt_state = st_fetch;
            end

            default: begin
                nxt_state = st_fetch;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
// The driver applies one cycle of inputs at a time and queues the output
// vector that cycle must show; the monitor pops and compares on each falling edge.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcen;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] aluc;
        logic       illegal;
    } out_t;

    localparam logic [31:0] i_lw   = 32'h8C00_0000;
    localparam logic [31:0] i_sw   = 32'hAC00_0000;
    localparam logic [31:0] i_beq  = 32'h1000_0000;
    localparam logic [31:0] i_addi = 32'h2000_0000;
    localparam logic [31:0] i_j    = 32'h0800_0000;
    localparam logic [31:0] i_slt  = 32'h0000_002A;
    localparam logic [31:0] i_sub  = 32'h0000_0022;
    localparam logic [31:0] i_or   = 32'h0000_0025;
    localparam logic [31:0] i_badf = 32'h0000_003F;
    localparam logic [31:0] i_bado = 32'hFC00_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        memwrite;
    logic        iord;
    logic        irwrite;
    logic        pcen;
    logic        regwrite;
    logic        regdst;
    logic        memtoreg;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  pcsrc;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic [3:0]  state;

    int checks = 0;
    int fails  = 0;
    out_t  exp_q[$];
    string name_q[$];

    multicycle_ctrl #(.MEM_HANDSHAKE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected Moore outputs per state, written out from the state table.
    function automatic out_t base(input logic [3:0] s);
        out_t e;
        e      = '0;
        e.st   = s;
        e.aluc = 3'b010;
        case (s)
            4'd1:  begin e.mem_req = 1'b1; e.alusrcb = 2'b01; end
            4'd2:  begin e.alusrcb = 2'b11; end
            4'd3:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd4:  begin e.mem_req = 1'b1; e.iord = 1'b1; end
            4'd5:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            4'd6:  begin e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = 1'b1; end
            4'd7:  begin e.alusrca = 1'b1; end
            4'd8:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
            4'd9:  begin e.alusrca = 1'b1; e.aluc = 3'b110; e.pcsrc = 2'b01; end
            4'd10: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd11: begin e.regwrite = 1'b1; end
            4'd12: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic out_t fetch_go();
        out_t e;
        e         = base(4'd1);
        e.irwrite = 1'b1;
        e.pcen    = 1'b1;
        return e;
    endfunction

    function automatic out_t with_aluc(input logic [3:0] s, input logic [2:0] a);
        out_t e;
        e      = base(s);
        e.aluc = a;
        return e;
    endfunction

    function automatic out_t with_ill(input logic [3:0] s);
        out_t e;
        e         = base(s);
        e.illegal = 1'b1;
        return e;
    endfunction

    function automatic out_t with_pcen(input logic [3:0] s, input logic p);
        out_t e;
        e      = base(s);
        e.pcen = p;
        return e;
    endfunction

    // Apply one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input string nm, input logic [31:0] i, input logic z,
                        input logic r, input out_t e);
        instr     = i;
        zero      = z;
        mem_ready = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        out_t  act;
        out_t  e;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act.st       = state;
            act.mem_req  = mem_req;
            act.memwrite = memwrite;
            act.iord     = iord;
            act.irwrite  = irwrite;
            act.pcen     = pcen;
            act.regwrite = regwrite;
            act.regdst   = regdst;
            act.memtoreg = memtoreg;
            act.alusrca  = alusrca;
            act.alusrcb  = alusrcb;
            act.pcsrc    = pcsrc;
            act.aluc     = alucontrol;
            act.illegal  = illegal;
            checks++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                         nm, act, act.st, e, e.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        instr     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, then released: one IDLE cycle then FETCH.
        step("rst_hold0", i_lw, 1'b0, 1'b1, base(4'd0));
        step("rst_hold1", i_lw, 1'b0, 1'b1, base(4'd0));
        rst_n = 1'b1;
        step("rst_rel_idle", i_lw, 1'b0, 1'b1, base(4'd0));

        // lw with memory always ready: 1,2,3,4,5.
        step("lw_fetch",  i_lw, 1'b0, 1'b1, fetch_go());
        step("lw_decode", i_lw, 1'b0, 1'b0, base(4'd2));
        step("lw_memadr", i_lw, 1'b0, 1'b1, base(4'd3));
        step("lw_memrd",  i_lw, 1'b0, 1'b1, base(4'd4));
        step("lw_memwb",  i_lw, 1'b0, 1'b1, base(4'd5));

        // FETCH stalled three cycles, then beq taken.
        step("stall_f1",    i_beq, 1'b1, 1'b0, base(4'd1));
        step("stall_f2",    i_beq, 1'b1, 1'b0, base(4'd1));
        step("stall_f3",    i_beq, 1'b1, 1'b0, base(4'd1));
        step("stall_f4go",  i_beq, 1'b1, 1'b1, fetch_go());
        step("beq_decode",  i_beq, 1'b1, 1'b1, base(4'd2));
        step("beq_taken",   i_beq, 1'b1, 1'b0, with_pcen(4'd9, 1'b1));

        // beq not taken.
        step("beqn_fetch",  i_beq, 1'b0, 1'b1, fetch_go());
        step("beqn_decode", i_beq, 1'b0, 1'b1, base(4'd2));
        step("beq_ntaken",  i_beq, 1'b0, 1'b1, with_pcen(4'd9, 1'b0));

        // R-type slt, sub, or.
        step("slt_fetch",  i_slt, 1'b0, 1'b1, fetch_go());
        step("slt_decode", i_slt, 1'b0, 1'b1, base(4'd2));
        step("slt_ex",     i_slt, 1'b0, 1'b1, with_aluc(4'd7, 3'b111));
        step("slt_wb",     i_slt, 1'b0, 1'b1, base(4'd8));
        step("sub_fetch",  i_sub, 1'b0, 1'b1, fetch_go());
        step("sub_decode", i_sub, 1'b0, 1'b1, base(4'd2));
        step("sub_ex",     i_sub, 1'b0, 1'b1, with_aluc(4'd7, 3'b110));
        step("sub_wb",     i_sub, 1'b0, 1'b1, base(4'd8));
        step("or_fetch",   i_or,  1'b0, 1'b1, fetch_go());
        step("or_decode",  i_or,  1'b0, 1'b1, base(4'd2));
        step("or_ex",      i_or,  1'b0, 1'b1, with_aluc(4'd7, 3'b001));
        step("or_wb",      i_or,  1'b0, 1'b1, base(4'd8));

        // Unknown funct: illegal in RTYPEEX, straight back to FETCH.
        step("badf_fetch",  i_badf, 1'b0, 1'b1, fetch_go());
        step("badf_decode", i_badf, 1'b0, 1'b1, base(4'd2));
        step("badf_ex",     i_badf, 1'b0, 1'b1, with_ill(4'd7));

        // Unknown opcode: illegal in DECODE, no writes, FETCH next.
        step("bado_fetch",  i_bado, 1'b0, 1'b1, fetch_go());
        step("bado_decode", i_bado, 1'b0, 1'b1, with_ill(4'd2));

        // sw with mem_ready delayed two cycles: memwrite held three cycles.
        step("sw_fetch",  i_sw, 1'b0, 1'b1, fetch_go());
        step("sw_decode", i_sw, 1'b0, 1'b1, base(4'd2));
        step("sw_memadr", i_sw, 1'b0, 1'b1, base(4'd3));
        step("sw_memwr1", i_sw, 1'b0, 1'b0, base(4'd6));
        step("sw_memwr2", i_sw, 1'b0, 1'b0, base(4'd6));
        step("sw_memwr3", i_sw, 1'b0, 1'b1, base(4'd6));

        // addi.
        step("addi_fetch",  i_addi, 1'b0, 1'b1, fetch_go());
        step("addi_decode", i_addi, 1'b0, 1'b1, base(4'd2));
        step("addi_ex",     i_addi, 1'b0, 1'b1, base(4'd10));
        step("addi_wb",     i_addi, 1'b0, 1'b1, base(4'd11));

        // j.
        step("j_fetch",  i_j, 1'b0, 1'b1, fetch_go());
        step("j_decode", i_j, 1'b0, 1'b1, base(4'd2));
        step("j_ex",     i_j, 1'b0, 1'b0, base(4'd12));

        // lw with MEMRD stalled one cycle.
        step("lws_fetch",  i_lw, 1'b0, 1'b1, fetch_go());
        step("lws_decode", i_lw, 1'b0, 1'b1, base(4'd2));
        step("lws_memadr", i_lw, 1'b0, 1'b1, base(4'd3));
        step("lws_memrd1", i_lw, 1'b0, 1'b0, base(4'd4));
        step("lws_memrd2", i_lw, 1'b0, 1'b1, base(4'd4));
        step("lws_memwb",  i_lw, 1'b0, 1'b1, base(4'd5));

        // Reset in the middle of a store drops mem_req/memwrite at once.
        step("swr_fetch",  i_sw, 1'b0, 1'b1, fetch_go());
        step("swr_decode", i_sw, 1'b0, 1'b1, base(4'd2));
        step("swr_memadr", i_sw, 1'b0, 1'b1, base(4'd3));
        step("swr_memwr",  i_sw, 1'b0, 1'b0, base(4'd6));
        rst_n = 1'b0;
        step("swr_rst0",   i_sw, 1'b0, 1'b1, base(4'd0));
        step("swr_rst1",   i_sw, 1'b0, 1'b1, base(4'd0));
        rst_n = 1'b1;
        step("swr_rel",    i_sw, 1'b0, 1'b1, base(4'd0));
        step("swr_refetch", i_sw, 1'b0, 1'b0, base(4'd1));

        // Every queued expectation must have been consumed by the monitor.
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
